// File: rtl/alu_pkg.sv
// Opcode map and legality check shared by the ALU,
// its decoder and the ALU sharing arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_LUI  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [3:0] ALU_OP_MAX = ALU_SLTU;

  function automatic logic is_legal_op(
    input logic [3:0] op
  );
    return (op <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester, ALU and response bundle of the
// shared-ALU arbiter.
interface alu_share_arb_if #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;

  logic [3:0]         alu_opcode;
  logic [31:0]        alu_in_a;
  logic [31:0]        alu_in_b;
  logic [31:0]        alu_out;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output alu_out, rsp_ready,
    input  req_ready, alu_opcode,
    input  alu_in_a, alu_in_b,
    input  rsp_valid, rsp_id,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  alu_out, rsp_ready,
    output req_ready, alu_opcode,
    output alu_in_a, alu_in_b,
    output rsp_valid, rsp_id,
    output rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter; the search
// starts at the index after the previous winner.
module rr_arb #(
  parameter int N   = 2,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    w_found = 1'b0;
    w_j     = 0;
    idx     = last_grant;
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(last_grant) + k) % N;
      if (!w_found && req[w_j]) begin
        w_found = 1'b1;
        idx     = IDW'(w_j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && w_found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external ALU with a
// one-entry tagged response register.
module alu_share_arb #(
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_share_arb_if.slave bus
);

  import alu_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic            r_rsp_valid;
  logic [31:0]     r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_err;
  logic [IDW-1:0]  r_last_grant;

  logic            w_can_accept;
  logic            w_en;
  logic            w_xfer;
  logic            w_legal;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic [3:0]      w_op;

  assign w_can_accept = !r_rsp_valid || bus.rsp_ready;
  assign w_en         = w_can_accept && !rst;

  rr_arb #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (r_last_grant),
    .en         (w_en),
    .gnt        (w_gnt),
    .idx        (w_idx)
  );

  assign w_xfer  = |w_gnt;
  assign w_op    = bus.req_op[4*int'(w_idx) +: 4];
  assign w_legal = is_legal_op(w_op);

  assign bus.req_ready  = w_gnt;
  assign bus.alu_opcode = w_op;
  assign bus.alu_in_a   = bus.req_a[32*int'(w_idx) +: 32];
  assign bus.alu_in_b   = bus.req_b[32*int'(w_idx) +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_rsp_err    <= 1'b0;
      r_last_grant <= IDW'(NREQ - 1);
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_data   <= w_legal ? bus.alu_out : '0;
      r_rsp_err    <= !w_legal;
      r_rsp_id     <= w_idx;
      r_last_grant <= w_idx;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with an
// external ALU model and a request-level reference.
module tb_alu_share_arb;

  localparam int NREQ = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_share_arb_if #(.NREQ(NREQ)) bus ();

  alu_share_arb #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return b;
      4'd3:  return a & b;
      4'd4:  return a ^ b;
      4'd5:  return a | b;
      4'd6:  return a << b[4:0];
      4'd7:  return a >> b[4:0];
      4'd8:  return $signed(a) >>> b[4:0];
      4'd9:  return {31'd0, $signed(a) < $signed(b)};
      4'd10: return {31'd0, a < b};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb
    bus.alu_out = alu_fn(bus.alu_opcode,
                         bus.alu_in_a, bus.alu_in_b);

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  int   m_last  = NREQ - 1;
  logic m_valid = 1'b0;

  logic [NREQ-1:0] v  = '0;
  logic            rr = 1'b1;
  logic [3:0]      op [NREQ];
  logic [31:0]     a  [NREQ];
  logic [31:0]     b  [NREQ];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[4*i +: 4] = op[i];
      bus.req_a[32*i +: 32] = a[i];
      bus.req_b[32*i +: 32] = b[i];
    end
  endtask

  task automatic step();
    int              w;
    logic            found;
    logic            can;
    logic [NREQ-1:0] er;
    logic            bad;
    drive();
    #1;
    can   = !m_valid || rr;
    found = 1'b0;
    w     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_last + k) % NREQ;
      if (!found && v[j]) begin
        found = 1'b1;
        w     = j;
      end
    end
    er = '0;
    if (can && found) er[w] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    if (found) begin
      chk("alu_opcode", 32'(bus.alu_opcode), 32'(op[w]));
      chk("alu_in_a", bus.alu_in_a, a[w]);
      chk("alu_in_b", bus.alu_in_b, b[w]);
    end
    @(posedge clk);
    if (can && found) begin
      bad = (op[w] > 4'd10);
      exp_q.push_back('{w,
        bad ? 32'h0 : alu_fn(op[w], a[w], b[w]), bad});
      m_last  = w;
      m_valid = 1'b1;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    #1;
    chk("req_ready_in_rst", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = NREQ - 1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_data", bus.rsp_data, 32'h0);
    chk("rst_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_err", 32'(bus.rsp_err), 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got id %0d data %h want none",
                   bus.rsp_id, bus.rsp_data);
        end else begin
          e = exp_q[0];
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < NREQ; i++) begin
      op[i] = '0;
      a[i]  = '0;
      b[i]  = '0;
    end
    drive();
    @(negedge clk);
    do_reset();

    v = 2'b01; rr = 1'b1;
    op[0] = 4'd0;
    a[0] = 32'h80000000; b[0] = 32'h80000000;
    step();
    chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_data", bus.rsp_data, 32'h0);
    chk("t1_id", 32'(bus.rsp_id), 32'h0);

    do_reset();
    v = 2'b11;
    op[0] = 4'd1;
    a[0] = 32'h70F0C0E0; b[0] = 32'h10003054;
    op[1] = 4'd6;
    a[1] = 32'hFFFFE0FF; b[1] = 32'h4;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_id", 32'(bus.rsp_id), 32'(k % 2));
      chk("t2_data", bus.rsp_data,
          (k % 2 == 0) ? 32'h60F0908C : 32'hFFFE0FF0);
    end

    rr = 1'b0;
    repeat (3) step();
    rr = 1'b1;
    step();
    chk("t3_next_id", 32'(bus.rsp_id), 32'h0);

    v = 2'b10;
    op[1] = 4'd8;
    a[1] = 32'hFFFFE0FF; b[1] = 32'h4;
    step();
    chk("t4_sra", bus.rsp_data, 32'hFFFFFE0F);
    op[1] = 4'd9;
    a[1] = 32'hFF000004; b[1] = 32'h700000FF;
    step();
    chk("t4_slt", bus.rsp_data, 32'h1);
    op[1] = 4'd10;
    step();
    chk("t4_sltu", bus.rsp_data, 32'h0);

    v = 2'b01;
    op[0] = 4'd13;
    a[0] = 32'h12345678; b[0] = 32'h1;
    step();
    chk("t5_err", 32'(bus.rsp_err), 32'h1);
    chk("t5_data", bus.rsp_data, 32'h0);
    op[0] = 4'd0; a[0] = 32'h1; b[0] = 32'h2;
    step();
    chk("t5_err_clr", 32'(bus.rsp_err), 32'h0);
    chk("t5_data2", bus.rsp_data, 32'h3);

    v = 2'b11; rr = 1'b0;
    step();
    do_reset();
    rr = 1'b1;
    step();
    chk("t6_first_id", 32'(bus.rsp_id), 32'h0);

    repeat (400) begin
      v  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        op[i] = 4'($urandom_range(0, 15));
        a[i]  = $urandom();
        b[i]  = $urandom();
      end
      step();
    end

    v = '0; rr = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0",
               exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares the single combinational ALU (4-bit opcode, two 32-bit operands, 32-bit result) between NREQ requesters, such as the execute stage and the address/branch-compare unit. Arbitration is round-robin with valid/ready handshakes. The block drives the ALU inputs from the granted request and captures the ALU result in a one-entry response register tagged with the requester index. It sits between the requesters and the ALU instance; the ALU itself stays outside this block.

## Interface
- NREQ, 2: number of requesters, 2..8.
- IDW, $clog2(NREQ): width of the requester index.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  in  4*NREQ  flat opcodes; requester i uses bits [4i+3:4i].
- req_a  in  32*NREQ  flat operand A buses.
- req_b  in  32*NREQ  flat operand B buses.
- alu_opcode  out  4  to ALU opcode input.
- alu_in_a  out  32  to ALU operand A.
- alu_in_b  out  32  to ALU operand B.
- alu_out  in  32  result from the ALU, combinational from the three outputs above.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  32  registered result.
- rsp_err  out  1  the opcode was illegal (11..15).

## Operation
- The opcode map is fixed: 0 add, 1 sub, 2 lui (result = b), 3 and, 4 xor, 5 or, 6 sll, 7 srl, 8 sra, 9 slt, 10 sltu.
- Shift amounts use b[4:0]. slt and sltu return 32'h1 or 32'h0.
- can_accept = !rsp_valid || rsp_ready.
- Arbiter:
  - Round-robin over req_valid, starting the search at the index after the last winner (last_grant + 1), wrapping modulo NREQ.
  - The winner is computed combinationally every cycle.
- req_ready[w] = can_accept && req_valid[w] for the winner w. All other bits are 0.
- A transfer happens when req_valid[i] && req_ready[i].
- ALU drive:
  - alu_opcode, alu_in_a and alu_in_b always carry the winner's fields.
  - With no valid request, they carry requester last_grant's fields; these values are don't-care.
- On a transfer:
  - rsp_data <= alu_out, or 32'h0 if the opcode ≥ 11.
  - rsp_err <= (opcode ≥ 11).
  - rsp_id <= w; rsp_valid <= 1; last_grant <= w.
- If rsp_valid && rsp_ready and there is no new transfer, rsp_valid <= 0 and the other response fields hold.
- Backpressure: while rsp_valid && !rsp_ready, all req_ready bits are 0 and rsp_* hold stable. last_grant does not change.
- Requester contract: a requester holds req_op, req_a and req_b stable while its req_valid is high and it is not yet accepted. The arbiter does not depend on this for correctness; it only samples fields on the transfer cycle.
- Simultaneous drain and accept in one cycle: the new result replaces the old one and rsp_valid stays 1.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, each is granted exactly once in every NREQ consecutive cycles.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
- last_grant resets to NREQ-1, so requester 0 has first priority after reset.
- req_ready is combinational from the current state, so it is 0 while rsp_valid && !rsp_ready.
- Latency: a request accepted in cycle N appears on rsp_* in cycle N+1.
- Throughput: one operation per cycle while rsp_ready=1.
- Reset asserted mid-operation:
  - Any pending response is discarded: rsp_valid=0 in the next cycle and no transfer occurs during the reset cycle.
  - req_ready is forced to 0 while rst=1.
- Combinational path: req_* → arbiter → ALU → response register. It must close in one clock cycle; there is no internal pipelining.
- No combinational path exists from rsp_ready to rsp_*. The only combinational path from rsp_ready is to req_ready.

## Structure
- Shared package alu_pkg:
  - Opcode localparams: ALU_ADD=4'd0 … ALU_SLTU=4'd10.
  - ALU_OP_MAX=4'd10.
  - The is_legal_op function.
- The ALU testbench and the decoder also use alu_pkg.
- One sub-module, rr_arb #(N):
  - Inputs: req[N], last_grant, en.
  - Outputs: one-hot gnt[N] and the winner index.
  - Purely combinational.
- This block holds only the response register and last_grant.

## Test plan
- Requester 0 sends op 0, a=32'h80000000, b=32'h80000000, with rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_data=32'h00000000, rsp_err=0.
- Both requesters valid for 4 cycles: requester 0 sends op 1 (70F0C0E0 − 10003054), requester 1 sends op 6 (FFFFE0FF << 4) → grants alternate 0,1,0,1 starting at 0; results are 32'h60F0908C and 32'hFFFE0FF0.
- rsp_ready=0 for 3 cycles with a response pending and both requesters valid → req_ready=0 throughout and rsp_* stable. After rsp_ready=1, the next grant goes to the index after the last winner.
- Requester 1 sends op 8 (a=FFFFE0FF, b=4), then op 9 and then op 10 (a=FF000004, b=700000FF) → results 32'hFFFFFE0F, 32'h1, 32'h0.
- Requester 0 sends op 4'd13 → rsp_err=1, rsp_data=0. The next legal request has rsp_err=0.
- Reset asserted for 1 cycle while rsp_valid=1 and both requesters valid → next cycle rsp_valid=0, all rsp_* zero, and the first grant after reset goes to requester 0.
